// File: rtl/noc_pkg.sv
// Shared constants and LFSR helpers for the multi-channel NoC sink.
package noc_pkg;

  localparam int unsigned TXN_CNT_W = 32;
  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  // One step of the 16-bit Galois LFSR (right shift, feedback from bit 0).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

  // Per-channel seed: base ^ channel, never the all-zero lock-up state.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base,
                                                  input int unsigned      ch);
    logic [LFSR_W-1:0] s;
    s = base ^ LFSR_W'(ch);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// In-order channel FIFO with arbitrary depth; a full FIFO never accepts a push.
module noc_fifo #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards any queued data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/noc_rr_sink.sv
// Multi-channel NoC sink: per-channel FIFOs drained round-robin onto one stream,
// with per-channel accept counters, done flags and optional LFSR backpressure.
module noc_rr_sink
  import noc_pkg::*;
#(
  parameter  int unsigned CH_NB        = 4,
  parameter  int unsigned DATA_W       = 64,
  parameter  int unsigned FIFO_DEPTH   = 4,
  parameter  int unsigned TXN_NB       = 1000,
  parameter  int unsigned RANDOM_STALL = 0,
  parameter  logic [15:0] SEED         = 16'hACE1,
  localparam int unsigned SRC_W        = (CH_NB > 1) ? $clog2(CH_NB) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_NB-1:0]     in_vld,
  output logic [CH_NB-1:0]     in_rdy,
  input  logic [DATA_W-1:0]    in_data [CH_NB],
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [DATA_W-1:0]    out_data,
  output logic [SRC_W-1:0]     out_src,
  output logic [TXN_CNT_W-1:0] txn_cnt [CH_NB],
  output logic [CH_NB-1:0]     ch_done,
  output logic                 all_done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CH_NB-1:0]     fifo_empty, fifo_full, push, pop;
  logic [DATA_W-1:0]    fifo_head [CH_NB];
  logic [CNT_W-1:0]     fifo_cnt  [CH_NB];
  logic [LFSR_W-1:0]    lfsr_q [CH_NB], lfsr_d [CH_NB];
  logic [TXN_CNT_W-1:0] txn_cnt_q [CH_NB], txn_cnt_d [CH_NB];
  logic [CH_NB-1:0]     ch_done_q, ch_done_d;
  logic                 all_done_q, all_done_d;
  logic                 rdy_en_q, rdy_en_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]     grant;
  logic                 any_vld, handshake;

  for (genvar g = 0; g < CH_NB; g++) begin : g_fifo
    noc_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .push_data (in_data[g]),
      .pop       (pop[g]),
      .head      (fifo_head[g]),
      .count     (fifo_cnt[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // Round-robin pick: first non-empty FIFO starting at rr_ptr.
  always_comb begin
    any_vld = 1'b0;
    grant   = '0;
    for (int unsigned k = 0; k < CH_NB; k++) begin
      if (!any_vld && !fifo_empty[(32'(rr_ptr_q) + k) % CH_NB]) begin
        any_vld = 1'b1;
        grant   = SRC_W'((32'(rr_ptr_q) + k) % CH_NB);
      end
    end
  end

  assign handshake = any_vld && out_rdy;
  assign out_vld   = any_vld;
  assign out_src   = any_vld ? grant : '0;
  assign out_data  = any_vld ? fifo_head[grant] : '0;
  assign txn_cnt   = txn_cnt_q;
  assign ch_done   = ch_done_q;
  assign all_done  = all_done_q;

  // Per-channel ready/accept, pop select, counters, done flags, LFSR and pointer update.
  always_comb begin
    in_rdy     = '0;
    push       = '0;
    pop        = '0;
    txn_cnt_d  = txn_cnt_q;
    ch_done_d  = ch_done_q;
    lfsr_d     = lfsr_q;
    rdy_en_d   = 1'b1;
    all_done_d = &ch_done_q;
    rr_ptr_d   = rr_ptr_q;
    for (int unsigned i = 0; i < CH_NB; i++) begin
      in_rdy[i] = rdy_en_q && (fifo_cnt[i] < CNT_W'(FIFO_DEPTH)) &&
                  ((RANDOM_STALL != 0) ? lfsr_q[i][0] : 1'b1);
      push[i]   = in_vld[i] && in_rdy[i];
      pop[i]    = handshake && (grant == SRC_W'(i));
      lfsr_d[i] = lfsr_next(lfsr_q[i]);
      if (push[i]) begin
        if (txn_cnt_q[i] != '1) txn_cnt_d[i] = txn_cnt_q[i] + TXN_CNT_W'(1);
        if (txn_cnt_q[i] == TXN_CNT_W'(TXN_NB - 1)) ch_done_d[i] = 1'b1;
      end
    end
    if (CH_NB == 1) begin
      rr_ptr_d = '0;
    end else if (handshake) begin
      rr_ptr_d = (grant == SRC_W'(CH_NB - 1)) ? '0 : grant + SRC_W'(1);
    end
  end

  // State registers; in_rdy stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH_NB; i++) begin
        lfsr_q[i]    <= lfsr_seed(SEED, i);
        txn_cnt_q[i] <= '0;
      end
      ch_done_q  <= '0;
      all_done_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      txn_cnt_q  <= txn_cnt_d;
      ch_done_q  <= ch_done_d;
      all_done_q <= all_done_d;
      rdy_en_q   <= rdy_en_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifndef SYNTHESIS
  int unsigned rx_cnt_q [CH_NB];

  // Simulation log of every delivered word and sanity check on FIFO overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH_NB; i++) rx_cnt_q[i] <= 0;
    end else begin
      assert ((push & fifo_full) == '0) else $error("noc_rr_sink: push into full fifo");
      if (handshake) begin
        $display("[cpu_%0d] NOC received 0x%0h (transaction %0d/%0d)",
                 out_src, out_data, rx_cnt_q[grant] + 1, TXN_NB);
        rx_cnt_q[grant] <= rx_cnt_q[grant] + 1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_rr_sink.sv
// Randomised bench for noc_rr_sink: two instances (no stall / LFSR stall) share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_noc_rr_sink;

  localparam int CH    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int TXN   = 8;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   in_vld;
  logic [DW-1:0]   in_data [CH];
  logic            out_rdy;

  logic [CH-1:0]   rdy0, rdy1, done0, done1;
  logic            vld0, vld1, all0, all1;
  logic [DW-1:0]   data0, data1;
  logic [1:0]      src0, src1;
  logic [31:0]     cnt0 [CH];
  logic [31:0]     cnt1 [CH];

  noc_rr_sink #(.CH_NB(CH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TXN_NB(TXN),
                .RANDOM_STALL(0), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy0), .in_data(in_data),
    .out_vld(vld0), .out_rdy(out_rdy), .out_data(data0), .out_src(src0),
    .txn_cnt(cnt0), .ch_done(done0), .all_done(all0));

  noc_rr_sink #(.CH_NB(CH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TXN_NB(TXN),
                .RANDOM_STALL(1), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy1), .in_data(in_data),
    .out_vld(vld1), .out_rdy(out_rdy), .out_data(data1), .out_src(src1),
    .txn_cnt(cnt1), .ch_done(done1), .all_done(all1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per (unit, channel), counters, flags, LFSR state.
  logic [DW-1:0] mq [2*CH][$];
  int            mcnt  [2][CH];
  logic [CH-1:0] mdone [2];
  logic          mall  [2];
  int            mrr   [2];
  logic [15:0]   mlfsr [2][CH];
  logic          men   [2];

  int            nvec;
  int            nerr;
  logic          use_fixed;
  logic [DW-1:0] fixed_data [CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < CH; c++) begin
        mq[u*CH+c].delete();
        mcnt[u][c]  = 0;
        mlfsr[u][c] = ((16'hACE1 ^ 16'(c)) == 16'h0) ? 16'h1 : (16'hACE1 ^ 16'(c));
      end
      mdone[u] = '0;
      mall[u]  = 1'b0;
      mrr[u]   = 0;
      men[u]   = 1'b0;
    end
  endtask

  // Expected ready vector and arbitration result for unit u in the current cycle.
  task automatic model_exp(input int u, output logic [CH-1:0] er, output logic ev,
                           output int es);
    ev = 1'b0;
    es = 0;
    for (int c = 0; c < CH; c++)
      er[c] = men[u] && (mq[u*CH+c].size() < DEPTH) && ((u == 0) || mlfsr[u][c][0]);
    for (int k = 0; k < CH; k++) begin
      if (!ev && mq[u*CH + (mrr[u]+k) % CH].size() != 0) begin
        ev = 1'b1;
        es = (mrr[u] + k) % CH;
      end
    end
  endtask

  task automatic model_step(input int u);
    logic [CH-1:0] er;
    logic          ev;
    int            es;
    logic [DW-1:0] tmp;
    logic          all_old;
    model_exp(u, er, ev, es);
    all_old = &mdone[u];
    if (ev && out_rdy) begin
      tmp = mq[u*CH+es].pop_front();
      mrr[u] = (es + 1) % CH;
    end
    for (int c = 0; c < CH; c++) begin
      if (in_vld[c] && er[c]) begin
        mq[u*CH+c].push_back(in_data[c]);
        mcnt[u][c]++;
        if (mcnt[u][c] == TXN) mdone[u][c] = 1'b1;
      end
      mlfsr[u][c] = lfsr_step(mlfsr[u][c]);
    end
    mall[u] = all_old;
    men[u]  = 1'b1;
  endtask

  task automatic check_unit(input int u);
    logic [CH-1:0] er, o_rdy, o_done;
    logic          ev, o_vld, o_all;
    int            es;
    logic [1:0]    o_src;
    logic [DW-1:0] o_data;
    logic [31:0]   o_cnt [CH];
    model_exp(u, er, ev, es);
    if (u == 0) begin
      o_rdy = rdy0; o_vld = vld0; o_src = src0; o_data = data0; o_done = done0; o_all = all0;
      for (int c = 0; c < CH; c++) o_cnt[c] = cnt0[c];
    end else begin
      o_rdy = rdy1; o_vld = vld1; o_src = src1; o_data = data1; o_done = done1; o_all = all1;
      for (int c = 0; c < CH; c++) o_cnt[c] = cnt1[c];
    end
    chk($sformatf("u%0d in_rdy", u), 64'(o_rdy), 64'(er));
    chk($sformatf("u%0d out_vld", u), 64'(o_vld), 64'(ev));
    if (ev) begin
      chk($sformatf("u%0d out_src", u), 64'(o_src), 64'(es));
      chk($sformatf("u%0d out_data", u), o_data, mq[u*CH+es][0]);
    end
    for (int c = 0; c < CH; c++)
      chk($sformatf("u%0d txn_cnt[%0d]", u, c), 64'(o_cnt[c]), 64'(mcnt[u][c]));
    chk($sformatf("u%0d ch_done", u), 64'(o_done), 64'(mdone[u]));
    chk($sformatf("u%0d all_done", u), 64'(o_all), 64'(mall[u]));
  endtask

  task automatic run_cycle(input logic [CH-1:0] v, input logic r);
    @(negedge clk);
    in_vld  = v;
    out_rdy = r;
    for (int c = 0; c < CH; c++)
      in_data[c] = use_fixed ? fixed_data[c] : {32'($urandom), 32'($urandom)};
    #1;
    check_unit(0);
    check_unit(1);
    model_step(0);
    model_step(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    in_vld  = '0;
    out_rdy = 1'b0;
    #1;
    model_reset();
    check_unit(0);
    check_unit(1);
    chk("rst out_data0", data0, 64'h0);
    chk("rst out_src0", 64'(src0), 64'h0);
    chk("rst out_data1", data1, 64'h0);
    chk("rst out_src1", 64'(src1), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_unit(0);
    check_unit(1);
    model_step(0);
    model_step(1);
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    use_fixed = 1'b0;
    rst_n     = 1'b0;
    in_vld    = '0;
    out_rdy   = 1'b0;
    for (int c = 0; c < CH; c++) begin
      in_data[c]    = '0;
      fixed_data[c] = '0;
    end
    do_reset();

    // ch2 burst 0x1,0x2,0x3 with the output always ready.
    use_fixed = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      fixed_data[2] = 64'(k);
      run_cycle(4'b0100, 1'b1);
    end
    repeat (6) run_cycle(4'b0000, 1'b1);

    // One word per channel, twice: grant order follows the rotating pointer.
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < CH; c++) fixed_data[c] = 64'hA0 + 64'(c) + 64'(rep * 16);
      run_cycle(4'b1111, 1'b1);
      repeat (6) run_cycle(4'b0000, 1'b1);
    end
    use_fixed = 1'b0;

    // ch0 fills its FIFO while blocked, then the output opens with in_vld held.
    repeat (6) run_cycle(4'b0001, 1'b0);
    repeat (3) run_cycle(4'b0001, 1'b1);
    repeat (8) run_cycle(4'b0000, 1'b1);

    // Long backpressure with ch1 and ch3 holding data: head must stay put.
    repeat (2) run_cycle(4'b1010, 1'b0);
    repeat (10) run_cycle(4'b0000, 1'b0);
    repeat (8) run_cycle(4'b0000, 1'b1);

    // Random traffic on all channels with random output readiness.
    for (int n = 0; n < 800; n++)
      run_cycle(4'($urandom), ($urandom_range(0, 3) != 0));

    // Reset with words queued, then more random traffic from a clean state.
    repeat (3) run_cycle(4'b0001, 1'b0);
    do_reset();
    for (int n = 0; n < 300; n++)
      run_cycle(4'($urandom), ($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
